muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits in the EX stage beside the combinational ALU. The pipeline stalls on `in_ready` and `out_valid`. Operands are taken through a valid/ready handshake, processed one bit per cycle, and the result is held until the consumer accepts it.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and operation-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldiv_state_e;

    function automatic logic is_div(muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic a_signed(muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle over a shared 2*W accumulator,
// sign handled as magnitude + fix-up, result held in DONE until accepted.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_LENGTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic [OP_LENGTH-1:0]  Operation,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

    muldiv_state_e    state, state_d;
    muldiv_op_e       op_q, op_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d, neg_r_q, neg_r_d;
    logic [W-1:0]     result_d;
    logic             out_valid_d;

    logic             a_neg, b_neg;
    logic [W-1:0]     a_mag, b_mag, quot, rem;
    logic [W:0]       mul_sum, div_diff;
    logic [2*W-1:0]   prod;

    // Next-state and datapath
    always_comb begin
        state_d     = state;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        neg_r_d     = neg_r_q;
        result_d    = Result;
        out_valid_d = out_valid;

        a_neg    = a_signed(op_q) & a_q[W-1];
        b_neg    = b_signed(op_q) & b_q[W-1];
        a_mag    = a_neg ? -a_q : a_q;
        b_mag    = b_neg ? -b_q : b_q;
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
        div_diff = acc_q[2*W-1:W-1] - {1'b0, opnd_q};
        prod     = neg_q ? -acc_q : acc_q;
        quot     = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem      = neg_r_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

        unique case (state)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d    = muldiv_op_e'(Operation[2:0]);
                    a_d     = SrcA;
                    b_d     = SrcB;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                neg_d   = a_neg ^ b_neg;
                neg_r_d = a_neg;
                cnt_d   = CNT_W'(W);
                if (is_div(op_q) && b_q == '0) begin
                    result_d    = (op_q inside {OP_REM, OP_REMU}) ? a_q : '1;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else if ((op_q inside {OP_DIV, OP_REM}) && a_q == {1'b1, {(W-1){1'b0}}}
                             && b_q == '1) begin
                    result_d    = (op_q == OP_DIV) ? a_q : '0;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    opnd_d  = is_div(op_q) ? b_mag : a_mag;
                    acc_d   = {{W{1'b0}}, (is_div(op_q) ? a_mag : b_mag)};
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Restoring divide keeps the quotient in the low half, remainder in the high half
                if (is_div(op_q)) begin
                    acc_d = div_diff[W] ? {acc_q[2*W-2:0], 1'b0}
                                        : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                end else begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                unique case (op_q)
                    OP_MUL:                       result_d = prod[W-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*W-1:W];
                    OP_DIV, OP_DIVU:              result_d = quot;
                    default:                      result_d = rem;
                endcase
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_r_q   <= 1'b0;
            Result    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            neg_r_q   <= neg_r_d;
            Result    <= result_d;
            out_valid <= out_valid_d;
            in_ready  <= (state_d == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, handshake/flush/reset behaviour, random ops.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  Operation;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_q[$];

    muldiv_unit #(.DATA_WIDTH(32), .OP_LENGTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .out_valid(out_valid), .out_ready(out_ready), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent 64-bit reference for the RV32M semantics
    function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        case (op)
            3'd0: return 32'(ua * ub);
            3'd1: return 32'((sa * sb) >>> 32);
            3'd2: return 32'((sa * longint'(ub)) >>> 32);
            3'd3: return 32'((ua * ub) >> 32);
            3'd4: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 32'd0) ? a : 32'(sa % sb);
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int special_lat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Operation = op;
        SrcA      = a;
        SrcB      = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int lat);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat));
    endtask

    // Pops the expected value; optionally stalls the consumer while junk input is offered
    task automatic finish_op(input string tag, input int hold);
        logic [31:0] exp = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            SrcA      = $urandom;
            SrcB      = $urandom;
            Operation = 3'($urandom_range(0, 7));
            check({tag, "_hold_result"}, Result, exp);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check({tag, "_result"}, Result, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
        exp_q.push_back(exp);
        start_op(op, a, b);
        wait_valid(tag, lat);
        finish_op(tag, hold);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        SrcA = '0; SrcB = '0; Operation = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", Result, 32'd0);
        #6 rst_n = 1'b1;
        @(posedge clk); #1;

        run("mul",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
        run("mulh",    3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34, 0);
        run("mulhu",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
        run("mulhsu",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
        run("div",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 0);
        run("rem",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 0);
        run("divu",    3'd5, 32'hFFFF_FFFF,  32'd16,        32'h0FFF_FFFF, 34, 0);
        run("div0",    3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  0);
        run("rem0",    3'd6, 32'd5,          32'd0,         32'd5,         1,  0);
        run("divovf",  3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
        run("removf",  3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  0);
        run("stall",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 10);
        run("after",   3'd0, 32'd9,          32'd11,        32'd99,        34, 0);

        // flush at CALC cycle 10
        start_op(3'd0, 32'd5, 32'd6);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);

        // flush wins over an accept in IDLE
        flush = 1'b1; in_valid = 1'b1; Operation = 3'd0; SrcA = 32'd2; SrcB = 32'd3;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_in_ready", 32'(in_ready), 32'd1);
        check("flush_idle_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  op = 3'($urandom_range(0, 7));
            logic [31:0] a  = $urandom;
            logic [31:0] b  = (i % 2 == 1) ? $urandom : 32'($urandom_range(0, 15));
            if (i == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; op = 3'd6; end
            run($sformatf("rnd%0d", i), op, a, b, ref_model(op, a, b), special_lat(op, a, b), 0);
        end

        // asynchronous reset in the middle of CALC, after a non-zero result
        run("prerst",  3'd5, 32'd1000,       32'd7,         32'd142,       34, 0);
        start_op(3'd0, 32'd123, 32'd456);
        repeat (12) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_result", Result, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("mul3x4",  3'd0, 32'd3,          32'd4,         32'd12,        34, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
